// File: rtl/relogio24h_ctrl_pkg.sv
//------------------------------------------------------------------------------
// relogio_pkg : shared state encoding and BCD digit limits for the 24 h clock
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package relogio_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

  localparam logic [3:0] MAX_UMIN        = 4'd9;
  localparam logic [3:0] MAX_DMIN        = 4'd5;
  localparam logic [3:0] MAX_UHOUR       = 4'd9;
  localparam logic [3:0] MAX_DHOUR       = 4'd2;
  localparam logic [3:0] WRAP_UHOUR_AT_2 = 4'd3;

endpackage

`default_nettype wire

// File: rtl/relogio24h_ctrl_if.sv
//------------------------------------------------------------------------------
// relogio24h_ctrl_if : control pulses in, BCD digits / state / pulses out
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface relogio24h_ctrl_if;

  logic       tick;
  logic       mode;
  logic       inc;
  logic [3:0] dhour;
  logic [3:0] uhour;
  logic [3:0] dmin;
  logic [3:0] umin;
  logic [1:0] state;
  logic       min_pulse;
  logic       day_pulse;

  modport master (
    output tick, mode, inc,
    input  dhour, uhour, dmin, umin, state, min_pulse, day_pulse
  );

  modport slave (
    input  tick, mode, inc,
    output dhour, uhour, dmin, umin, state, min_pulse, day_pulse
  );

endinterface

`default_nettype wire

// File: rtl/relogio24h_ctrl_bcd_digit_en.sv
//------------------------------------------------------------------------------
// bcd_digit_en : one enabled BCD digit that wraps at a programmable maximum
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_en (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] max,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (en) begin
      q_d = (q_q == max) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en && (q_q == max);

endmodule

`default_nettype wire

// File: rtl/relogio24h_ctrl.sv
//------------------------------------------------------------------------------
// relogio24h_ctrl : HH:MM BCD clock sequencer with hour/minute set mode
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module relogio24h_ctrl
  import relogio_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic              clk,
  input  logic              reset,
  relogio24h_ctrl_if.slave  bus
);

  localparam int            PW           = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] c_PRESC_LAST = PW'(TICKS_PER_MIN - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          min_pulse_q, min_pulse_d;
  logic          day_pulse_q, day_pulse_d;

  logic       w_in_run, w_in_hour, w_in_min;
  logic       w_inc, w_min_tick;
  logic       w_umin_en, w_hour_en;
  logic       w_umin_carry, w_dmin_carry, w_uhour_carry, w_dhour_carry;
  logic [3:0] w_uhour_max;

  assign w_in_run   = (state_q == RUN);
  assign w_in_hour  = (state_q == SET_HOUR);
  assign w_in_min   = (state_q == SET_MIN);
  assign w_inc      = bus.inc & ~bus.mode;
  assign w_min_tick = w_in_run & bus.tick & (presc_q == c_PRESC_LAST);

  assign w_umin_en  = w_min_tick | (w_in_min & w_inc);
  // Minute rollover only reaches the hour digits under tick control.
  assign w_hour_en  = (w_dmin_carry & w_min_tick) | (w_in_hour & w_inc);
  assign w_uhour_max = (bus.dhour == MAX_DHOUR) ? WRAP_UHOUR_AT_2 : MAX_UHOUR;

  bcd_digit_en u_umin (
    .clk(clk), .reset(reset), .en(w_umin_en), .clr(1'b0),
    .max(MAX_UMIN), .q(bus.umin), .carry(w_umin_carry)
  );

  bcd_digit_en u_dmin (
    .clk(clk), .reset(reset), .en(w_umin_carry), .clr(1'b0),
    .max(MAX_DMIN), .q(bus.dmin), .carry(w_dmin_carry)
  );

  // dhour carries only at 23 -> that carry is the 23:xx -> 00:xx clear.
  bcd_digit_en u_uhour (
    .clk(clk), .reset(reset), .en(w_hour_en), .clr(w_dhour_carry),
    .max(w_uhour_max), .q(bus.uhour), .carry(w_uhour_carry)
  );

  bcd_digit_en u_dhour (
    .clk(clk), .reset(reset), .en(w_uhour_carry), .clr(w_dhour_carry),
    .max(MAX_DHOUR), .q(bus.dhour), .carry(w_dhour_carry)
  );

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    min_pulse_d = w_min_tick;
    day_pulse_d = w_min_tick & w_dhour_carry;
    case (state_q)
      RUN: begin
        if (bus.tick) begin
          presc_d = (presc_q == c_PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
        if (bus.mode) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (bus.mode) state_d = SET_MIN;
      end
      SET_MIN: begin
        if (bus.mode) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      presc_q     <= '0;
      min_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      min_pulse_q <= min_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.min_pulse = min_pulse_q;
  assign bus.day_pulse = day_pulse_q;

endmodule

`default_nettype wire

// File: doc/relogio24h_ctrl.md
# relogio24h_ctrl

Single-clock controller that sequences the four BCD digits of the 24-hour clock (HH:MM) from a time-base tick. It also provides a user set mode for hours and minutes. All digit counters advance on one clock with enables; there are no ripple clocks. The block sits between the time-base prescaler and the display driver.

## Interface
- `TICKS_PER_MIN`, default 60: number of `tick` pulses per minute advance; legal range ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; `reset`==0 at a rising edge clears all state.
- `tick`  in  1  one-cycle pulse from the time base; synchronous to `clk`.
- `mode`  in  1  one-cycle pulse, already debounced; advances the set-mode FSM.
- `inc`  in  1  one-cycle pulse, already debounced; increments the selected field in set mode.
- `dhour`  out  4  hour tens, BCD 0–2.
- `uhour`  out  4  hour units, BCD 0–9; 0–3 when `dhour`==2.
- `dmin`  out  4  minute tens, BCD 0–5.
- `umin`  out  4  minute units, BCD 0–9.
- `state`  out  2  FSM state: RUN=0, SET_HOUR=1, SET_MIN=2.
- `min_pulse`  out  1  high for one cycle when a tick-driven minute advance becomes visible.
- `day_pulse`  out  1  high for one cycle when the time wraps from 23:59 to 00:00 under tick control.

## Operation
- Reset values: all digits 0 (time 00:00), `state`=RUN, prescaler 0, `min_pulse`=0, `day_pulse`=0.
- **RUN state**
  - On `tick`: if the prescaler equals `TICKS_PER_MIN`-1, it clears to 0 and the minute advances; otherwise the prescaler increments.
- **Minute advance**
  - `umin` goes 9→0 with a carry into `dmin`.
  - `dmin` goes 5→0 (only on `umin` carry) and advances the hour.
- **Hour advance**
  - `uhour` goes 9→0 with a carry into `dhour`.
  - At 23, the hour wraps to 00 (`dhour`=0, `uhour`=0) and `day_pulse` is asserted.
- **Mode FSM**
  - A `mode` pulse steps the state RUN→SET_HOUR→SET_MIN→RUN.
  - No other transitions exist; state encoding 3 is unreachable and recovers to RUN on the next edge.
- **SET_HOUR**
  - `tick` is ignored and the prescaler is frozen.
  - `inc` adds one hour, wrapping 23→00.
  - Minutes are unchanged; no `day_pulse` and no `min_pulse`.
- **SET_MIN**
  - `tick` is ignored.
  - `inc` adds one minute, wrapping 59→00 with no carry into the hour; no pulses.
- Leaving SET_MIN for RUN clears the prescaler to 0, so the first minute after setting is a full `TICKS_PER_MIN` ticks.
- **Simultaneous events**
  - `mode`+`inc` in the same cycle: `mode` wins and `inc` is dropped.
  - `mode`+`tick` in RUN: the tick is processed normally and the state moves to SET_HOUR on the same edge.
- **Invariant:** the outputs always hold valid BCD in the range 00:00–23:59.
- **Reset mid-operation:** reset overrides everything, including any pending pulse.

## Timing
- Every output is a register.
- A digit change is visible one cycle after the edge that samples `tick`/`inc`.
- `min_pulse` and `day_pulse` rise in the same cycle as the new digit values and last exactly one cycle.
- On the 23:59→00:00 wrap, `min_pulse` and `day_pulse` are both high in the same cycle.
- With `TICKS_PER_MIN`=1, every RUN-state tick advances the minute; back-to-back ticks give back-to-back `min_pulse` cycles.
- The prescaler width is max(1, $clog2(`TICKS_PER_MIN`)).

## Structure
- Package `relogio_pkg` holds:
  - the state enum (RUN, SET_HOUR, SET_MIN);
  - digit limit constants: `MAX_UMIN`=9, `MAX_DMIN`=5, `MAX_UHOUR`=9, `MAX_DHOUR`=2, `WRAP_UHOUR_AT_2`=3.
- Sub-module `bcd_digit_en` is a 4-bit BCD digit register:
  - ports: `clk`, `reset`, `en`, `clr`, `max` input, `q`, `carry`;
  - `carry` = `en` && (`q`==`max`);
  - four instances; the controller computes the enables, the hour `max`, and the 23→00 clear.

## Test plan
1. Hold `reset`=0 for 2 cycles after random activity → 00:00, `state`=0, pulses 0.
2. `TICKS_PER_MIN`=4:
   - 3 ticks → still 00:00;
   - 4th tick → 00:01 with `min_pulse` high for exactly 1 cycle.
3. Use set mode to load 09:59, then 4 ticks → 10:00. Load 19:59 → 20:00. Load 23:59 → 00:00 with `min_pulse` and `day_pulse` together; `day_pulse` absent on the other two wraps.
4. Set mode, starting from 00:00:
   - `mode`, then 25×`inc` → 01:00, no `day_pulse`;
   - `mode`, then 61×`inc` → 01:01, no pulses;
   - 10 ticks interleaved throughout → no effect;
   - `mode` → RUN, then 4 ticks → 01:02.
5. `mode`+`inc` in the same cycle while in SET_HOUR → state SET_MIN, hour unchanged. `mode`+`tick` on the 4th tick in RUN → minute advances and state becomes SET_HOUR.
6. `reset`=0 for 1 cycle while in SET_MIN at 14:37 → 00:00, RUN. Next 4 ticks → 00:01.
